// File: rtl/ara_pkg.sv
// Shared types and constants for the ARA invalidation scheduler.
// Holds the scheduler FSM state type and the statistics counter width.
package ara_pkg;

  // Width of the optional push/coalesce statistics counters.
  localparam int unsigned StatWidth = 32;

  // Scheduler control states.
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACTIVE = 2'd1,
    STATE_FLUSH  = 2'd2
  } inval_sched_state_e;

endpackage : ara_pkg

// File: rtl/ara_inval_sched.sv
// ARA invalidation scheduler: a small coalescing FIFO between the AXI write
// filter and the CVA6 L1 D-cache invalidation port. Incoming addresses are
// line-aligned; an address already waiting in the queue is dropped instead of
// queued twice. A flush request blocks new input and reports completion with
// a one-cycle flush_done_o pulse once the queue has drained.
//
// Optional statistics counters are built when ARA_INVAL_SCHED_STATS_EN is
// defined; otherwise stat_pushed_o and stat_coalesced_o are tied to zero.
module ara_inval_sched
  import ara_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  // upstream invalidation from the AXI write filter
  input  logic [AddrWidth-1:0]       inval_addr_i,
  input  logic                       inval_valid_i,
  output logic                       inval_ready_o,
  // downstream invalidation to the L1
  output logic [AddrWidth-1:0]       inval_addr_o,
  output logic                       inval_valid_o,
  input  logic                       inval_ready_i,
  // drain control
  input  logic                       flush_i,
  output logic                       flush_done_o,
  // status
  output logic                       busy_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  output logic [StatWidth-1:0]       stat_pushed_o,
  output logic [StatWidth-1:0]       stat_coalesced_o
);

  localparam int unsigned OffsetBits = $clog2(L1LineWidth);
  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CntWidth   = $clog2(Depth+1);

  localparam logic [CntWidth-1:0]  DepthCnt = CntWidth'(Depth);
  localparam logic [AddrWidth-1:0] LineMask =
    ~((AddrWidth'(1) << OffsetBits) - AddrWidth'(1));

  logic [AddrWidth-1:0] mem_q [Depth];
  logic [Depth-1:0]     valid_q;
  logic [PtrWidth-1:0]  head_q, tail_q;
  logic [CntWidth-1:0]  count_q;
  inval_sched_state_e   state_q, state_d;

  logic [AddrWidth-1:0] addr_aligned;
  logic                 empty, full;
  logic                 hit, pop, push, handshake;

  assign addr_aligned = inval_addr_i & LineMask;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthCnt);
  assign pop          = !empty && inval_ready_i;

  // Hit detection: the new line matches a waiting entry. The head entry is
  // excluded when it leaves this cycle, otherwise the line would be dropped
  // after the L1 has already consumed its older copy.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i] && (mem_q[i] == addr_aligned) &&
          !(pop && (PtrWidth'(i) == head_q))) begin
        hit = 1'b1;
      end
    end
  end

  // A hit can always be accepted (it is absorbed), even when the queue is full.
  assign inval_ready_o = en_i && (state_q != STATE_FLUSH) && (!full || hit);
  assign handshake     = inval_valid_i && inval_ready_o;
  assign push          = handshake && !hit;

  // Entry storage: written at the tail on every push.
  // NOTE: the address array is deliberately not reset; valid_q and count_q
  // decide which slots mean anything, so stale data is never observable.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[tail_q] <= addr_aligned;
    end
  end

  // Queue bookkeeping: per-entry valid bits, wrapping pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pop clears before push sets, so a same-slot reuse keeps the new entry.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrWidth'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrWidth'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic for the IDLE / ACTIVE / FLUSH controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE: begin
        if (flush_i)   state_d = STATE_FLUSH;
        else if (push) state_d = STATE_ACTIVE;
      end
      STATE_ACTIVE: begin
        if (flush_i) begin
          state_d = STATE_FLUSH;
        end else if ((count_q == CntWidth'(1)) && pop && !push) begin
          state_d = STATE_IDLE;
        end
      end
      STATE_FLUSH: begin
        // Completing the drain takes priority over a flush request held high.
        if (empty) state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from registered state only; the head address is
  // forced to zero while the queue is empty so it never exposes stale data.
  assign inval_valid_o = !empty;
  assign inval_addr_o  = empty ? '0 : mem_q[head_q];
  assign busy_o        = !empty || (state_q == STATE_FLUSH);
  assign flush_done_o  = (state_q == STATE_FLUSH) && empty;
  assign occupancy_o   = count_q;

`ifdef ARA_INVAL_SCHED_STATS_EN
  logic                 coalesce;
  logic [StatWidth-1:0] pushed_q, coalesced_q;

  assign coalesce = handshake && hit;

  // Free-running statistics counters; they wrap naturally at 2^StatWidth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pushed_q    <= '0;
      coalesced_q <= '0;
    end else begin
      if (push)     pushed_q    <= pushed_q + StatWidth'(1);
      if (coalesce) coalesced_q <= coalesced_q + StatWidth'(1);
    end
  end

  assign stat_pushed_o    = pushed_q;
  assign stat_coalesced_o = coalesced_q;
`else
  assign stat_pushed_o    = '0;
  assign stat_coalesced_o = '0;
`endif

endmodule : ara_inval_sched

// File: tb/tb_ara_inval_sched.sv
// Self-checking bench for ara_inval_sched (Depth=4, 16-byte lines).
// A queue-based reference model predicts every output each cycle; directed
// scenarios are followed by a randomized phase.
module tb_ara_inval_sched;

  localparam int DEPTH = 4;
  localparam int LINE  = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [63:0] inval_addr_i;
  logic        inval_valid_i;
  logic        inval_ready_o;
  logic [63:0] inval_addr_o;
  logic        inval_valid_o;
  logic        inval_ready_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        busy_o;
  logic [2:0]  occupancy_o;
  logic [31:0] stat_pushed_o;
  logic [31:0] stat_coalesced_o;

  ara_inval_sched #(
    .AddrWidth  (64),
    .L1LineWidth(LINE),
    .Depth      (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .inval_addr_i    (inval_addr_i),
    .inval_valid_i   (inval_valid_i),
    .inval_ready_o   (inval_ready_o),
    .inval_addr_o    (inval_addr_o),
    .inval_valid_o   (inval_valid_o),
    .inval_ready_i   (inval_ready_i),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o),
    .occupancy_o     (occupancy_o),
    .stat_pushed_o   (stat_pushed_o),
    .stat_coalesced_o(stat_coalesced_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the queue of pending line addresses plus a flushing flag.
  logic [63:0] q[$];
  bit          m_flush;
  int          m_pushed, m_coal;
  bit          m_pop, m_hit, m_ready, m_empty;
  logic [63:0] m_aligned;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush  = 0;
    m_pushed = 0;
    m_coal   = 0;
  endtask

  // Apply inputs after the falling edge, predict, and compare every output.
  task automatic drive(input logic v, input logic [63:0] a, input logic rdy,
                       input logic en, input logic fl);
    @(negedge clk);
    inval_valid_i = v;
    inval_addr_i  = a;
    inval_ready_i = rdy;
    en_i          = en;
    flush_i       = fl;
    #1;
    m_aligned = a & ~64'(LINE - 1);
    m_empty   = (q.size() == 0);
    m_pop     = !m_empty && rdy;
    m_hit     = 0;
    for (int j = (m_pop ? 1 : 0); j < q.size(); j++)
      if (q[j] == m_aligned) m_hit = 1;
    m_ready = en && !m_flush && ((q.size() < DEPTH) || m_hit);

    check("ready",      inval_ready_o, m_ready);
    check("valid",      inval_valid_o, !m_empty);
    check("addr",       inval_addr_o,  m_empty ? 64'd0 : q[0]);
    check("occupancy",  occupancy_o,   q.size());
    check("busy",       busy_o,        !m_empty || m_flush);
    check("flush_done", flush_done_o,  m_flush && m_empty);
`ifdef ARA_INVAL_SCHED_STATS_EN
    check("stat_pushed",    stat_pushed_o,    m_pushed);
    check("stat_coalesced", stat_coalesced_o, m_coal);
`else
    check("stat_pushed",    stat_pushed_o,    64'd0);
    check("stat_coalesced", stat_coalesced_o, 64'd0);
`endif
  endtask

  // Advance one clock edge and update the model with the handshakes seen.
  task automatic tick();
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (inval_valid_i && m_ready) begin
      if (m_hit) m_coal++;
      else begin
        q.push_back(m_aligned);
        m_pushed++;
      end
    end
    if (m_flush) begin
      if (m_empty) m_flush = 0;
    end else if (flush_i) begin
      m_flush = 1;
    end
  endtask

  task automatic cycle(input logic v, input logic [63:0] a, input logic rdy,
                       input logic en, input logic fl);
    drive(v, a, rdy, en, fl);
    tick();
  endtask

  initial begin
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    inval_addr_i  = '0;
    inval_valid_i = 1'b0;
    inval_ready_i = 1'b0;
    flush_i       = 1'b0;
    model_reset();

    // Reset state.
    #1;
    check("rst_ready",      inval_ready_o, 1);
    check("rst_valid",      inval_valid_o, 0);
    check("rst_addr",       inval_addr_o,  0);
    check("rst_occ",        occupancy_o,   0);
    check("rst_busy",       busy_o,        0);
    check("rst_flush_done", flush_done_o,  0);
    check("rst_stat_push",  stat_pushed_o, 0);
    check("rst_stat_coal",  stat_coalesced_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Coalescing: two addresses in the same line produce one output.
    cycle(1, 64'h1004, 0, 1, 0);
    drive(1, 64'h100C, 0, 1, 0);
    check("coal_ready", inval_ready_o, 1);
    tick();
    drive(0, 0, 1, 1, 0);
    check("coal_out",  inval_addr_o, 64'h1000);
    check("coal_occ",  occupancy_o,  1);
`ifdef ARA_INVAL_SCHED_STATS_EN
    check("coal_stat", stat_coalesced_o, 1);
`endif
    tick();
    drive(0, 0, 1, 1, 0);
    check("coal_single", inval_valid_o, 0);
    tick();

    // Full with backpressure; a hit is still accepted at full.
    cycle(1, 64'h000, 0, 1, 0);
    cycle(1, 64'h010, 0, 1, 0);
    cycle(1, 64'h020, 0, 1, 0);
    cycle(1, 64'h030, 0, 1, 0);
    drive(1, 64'h040, 0, 1, 0);
    check("full_ready", inval_ready_o, 0);
    check("full_occ",   occupancy_o,   4);
    tick();
    drive(1, 64'h020, 0, 1, 0);
    check("full_hit_ready", inval_ready_o, 1);
    tick();
    drive(0, 0, 1, 1, 0);
    check("full_head", inval_addr_o, 64'h000);
    tick();
    repeat (4) cycle(0, 0, 1, 1, 0);

    // Head-pop exclusion: the popping head's line is queued again.
    cycle(1, 64'h200, 0, 1, 0);
    drive(1, 64'h208, 1, 1, 0);
    check("hx_ready", inval_ready_o, 1);
    tick();
    drive(0, 0, 1, 1, 0);
    check("hx_valid", inval_valid_o, 1);
    check("hx_addr",  inval_addr_o,  64'h200);
    tick();
    drive(0, 0, 1, 1, 0);
    check("hx_empty", inval_valid_o, 0);
    tick();

    // Flush with three entries queued.
    cycle(1, 64'h300, 0, 1, 0);
    cycle(1, 64'h310, 0, 1, 0);
    cycle(1, 64'h320, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    drive(1, 64'h330, 0, 1, 0);
    check("fl_ready", inval_ready_o, 0);
    check("fl_busy",  busy_o,        1);
    tick();
    repeat (3) cycle(0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("fl_done", flush_done_o, 1);
    tick();
    drive(0, 0, 0, 1, 0);
    check("fl_done_once", flush_done_o, 0);
    check("fl_idle_busy", busy_o,       0);
    tick();

    // Flush while empty completes on the next cycle.
    cycle(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    check("fle_done", flush_done_o, 1);
    tick();
    cycle(0, 0, 0, 1, 0);

    // Enable off: no new input, queued entries still drain in order.
    cycle(1, 64'h400, 0, 1, 0);
    cycle(1, 64'h410, 0, 1, 0);
    drive(1, 64'h420, 0, 0, 0);
    check("en_ready", inval_ready_o, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    check("en_first", inval_addr_o, 64'h400);
    tick();
    drive(0, 0, 1, 0, 0);
    check("en_second", inval_addr_o, 64'h410);
    tick();
    cycle(0, 0, 1, 0, 0);

    // Reset mid-drain while a flush is in progress.
    cycle(1, 64'h500, 0, 1, 0);
    cycle(1, 64'h510, 0, 1, 0);
    cycle(1, 64'h520, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mr_valid",      inval_valid_o, 0);
    check("mr_occ",        occupancy_o,   0);
    check("mr_flush_done", flush_done_o,  0);
    check("mr_busy",       busy_o,        0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic over a small address pool to provoke hits.
    for (int n = 0; n < 1500; n++) begin
      logic [63:0] ra;
      ra = (64'($urandom_range(0, 7)) << 4) | 64'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, ra, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    repeat (8) cycle(0, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_ara_inval_sched

// File: doc/ara_inval_sched.md
ARA_INVAL_SCHED -- requirements
Module: ara_inval_sched

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, address width in bits.
REQ-002 SHALL have parameter L1LineWidth, default 16, L1 D-cache line size in bytes (power of two).
REQ-003 SHALL have parameter Depth, default 4, number of queue entries (power of two, >=2).
REQ-004 SHALL have port clk_i, input, 1, sole clock.
REQ-005 SHALL have port rst_ni, input, 1, reset; one clock, asynchronous active-low reset.
REQ-006 SHALL have port en_i, input, 1, consistency enable; gates acceptance of new invalidations.
REQ-007 SHALL have ports inval_addr_i (input, AddrWidth), inval_valid_i (input, 1) and inval_ready_o (output, 1): upstream invalidation from the AXI write filter.
REQ-008 SHALL have ports inval_addr_o (output, AddrWidth), inval_valid_o (output, 1) and inval_ready_i (input, 1): downstream invalidation to the CVA6 L1.
REQ-009 SHALL have ports flush_i (input, 1), drain request, and flush_done_o (output, 1), drain-complete pulse.
REQ-010 SHALL have ports busy_o (output, 1), queue non-empty or FLUSH, and occupancy_o (output, $clog2(Depth+1)), valid entry count.
REQ-011 SHALL have ports stat_pushed_o and stat_coalesced_o, each output, 32 bits, statistics counters.

Function
REQ-012 SHALL store each accepted address line-aligned: low $clog2(L1LineWidth) bits zeroed.
REQ-013 SHALL compute hit when the aligned inval_addr_i equals any valid entry, excluding the head entry when it pops in the same cycle.
REQ-014 SHALL drive inval_ready_o = en_i & (state != FLUSH) & (!full | hit), combinationally.
REQ-015 SHALL discard a handshaked input on hit (coalesce), and otherwise push it at the tail.
REQ-016 SHALL expose a pushed entry on inval_valid_o no earlier than the next cycle; the minimum push-to-valid latency is 1 cycle.
REQ-017 SHALL drive inval_valid_o = !empty and inval_addr_o = head entry, both registered-state only.
REQ-018 SHALL hold inval_addr_o stable while inval_valid_o & !inval_ready_i.
REQ-019 SHALL pop the head on inval_valid_o & inval_ready_i, and SHALL allow a push and a pop in the same cycle with occupancy unchanged.
REQ-020 SHALL wrap the head and tail pointers modulo Depth; full = (occupancy == Depth).
REQ-021 SHALL implement FSM IDLE / ACTIVE / FLUSH with these transitions:
- IDLE->ACTIVE on a push.
- ACTIVE->IDLE when the last entry pops with no push.
- any->FLUSH on flush_i.
- FLUSH->IDLE once empty, asserting flush_done_o for exactly that one cycle.
REQ-022 SHALL assert flush_done_o in the cycle after flush_i when flush_i rises while empty.
REQ-023 SHALL, when en_i deasserts, stop accepting new addresses but keep draining the entries already queued.
REQ-024 SHALL keep downstream order FIFO: no reordering.

Reset
REQ-025 SHALL reset asynchronously: state IDLE, pointers 0, entries invalid, every output 0 (inval_ready_o follows REQ-014 and so depends on en_i).
REQ-026 SHALL discard queued entries on reset asserted mid-operation, with no flush_done_o pulse.

Configuration
REQ-027 SHALL use macro ARA_INVAL_SCHED_STATS_EN.
- Defined: stat_pushed_o counts pushes and stat_coalesced_o counts coalesced inputs; both wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Structure
REQ-028 SHALL place the FSM enum type inval_sched_state_e and the stat-counter width constant in ara_pkg.
REQ-029 SHALL implement storage and compare inline with no sub-module, because hit detection needs all entries visible.

Verification (Depth=4, L1LineWidth=16)
REQ-030 SHALL cover coalescing: push 0x1004, then 0x100C before the pop -> a single output 0x1000; stat_coalesced_o=1.
REQ-031 SHALL cover full with backpressure: inval_ready_i=0, push 0x000,0x010,0x020,0x030, then 0x040 -> inval_ready_o=0 at occupancy 4; push 0x020 -> accepted (hit).
REQ-032 SHALL cover head-pop exclusion: head 0x200 pops in the same cycle that 0x208 arrives -> 0x200 is re-queued and output again.
REQ-033 SHALL cover flush: three entries queued, flush_i pulsed -> inval_ready_o=0; flush_done_o pulses one cycle after the third pop; FSM returns to IDLE.
REQ-034 SHALL cover enable off: en_i=0 with two entries queued -> inval_ready_o=0, both entries still emitted in order.
REQ-035 SHALL cover reset mid-drain: rst_ni low with occupancy 3 -> inval_valid_o=0, occupancy_o=0, flush_done_o=0 immediately.
